// File: rtl/grammer_pkg.sv
// Shared encodings for the array-stage output collector: display FSM states,
// disp_sel codes and the default data width.
package grammer_pkg;

  localparam int DEFAULT_DW = 32;

  typedef enum logic [1:0] {
    DISP_IDLE = 2'd0,
    DISP_SUM  = 2'd1,
    DISP_MAX  = 2'd2,
    DISP_MIN  = 2'd3
  } disp_state_e;

  localparam logic [1:0] DISP_SEL_NONE = 2'd0;
  localparam logic [1:0] DISP_SEL_SUM  = 2'd1;
  localparam logic [1:0] DISP_SEL_MAX  = 2'd2;
  localparam logic [1:0] DISP_SEL_MIN  = 2'd3;

  // Selector code shown on disp_sel while the FSM sits in a given state.
  function automatic logic [1:0] disp_sel_of(input disp_state_e s);
    logic [1:0] sel;
    sel = DISP_SEL_NONE;
    case (s)
      DISP_SUM: sel = DISP_SEL_SUM;
      DISP_MAX: sel = DISP_SEL_MAX;
      DISP_MIN: sel = DISP_SEL_MIN;
      default:  sel = DISP_SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/array_out_collector_if.sv
// Bus between the array stage / sink / display side and the collector.
// master = environment side, slave = collector.
interface array_out_collector_if
  import grammer_pkg::*;
#(
  parameter int DW  = DEFAULT_DW,
  parameter int WIN = 4
);
  localparam int SW = DW + $clog2(WIN);

  logic [DW-1:0] data_in;
  logic          in_valid;
  logic          sig_display;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          stat_valid;
  logic [SW-1:0] disp_data;
  logic [1:0]    disp_sel;
  logic [7:0]    ovf_cnt;

  modport master (
    output data_in, in_valid, sig_display, dout_ready,
    input  dout, dout_valid, stat_valid, disp_data, disp_sel, ovf_cnt
  );

  modport slave (
    input  data_in, in_valid, sig_display, dout_ready,
    output dout, dout_valid, stat_valid, disp_data, disp_sel, ovf_cnt
  );
endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, first-word-fall-through head. A push is refused when
// full unless a pop frees the slot in the same cycle; a pop on empty is ignored.
module sync_fifo
  import grammer_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_head,
  output logic          o_full,
  output logic          o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_push, w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  // Head reads 0 while empty so dout is clean after reset.
  assign o_head    = o_empty ? '0 : r_mem[r_rptr];

  // Storage array; contents are only observed behind a valid pointer.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH (power of 2); occupancy tracks push/pop.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/array_out_collector.sv
// Collector for the array stage's output words: FIFO to a valid/ready sink,
// per-window sum/max/min statistics, drop counter, and a display sequencer
// that walks sum -> max -> min on a sig_display rising edge.
module array_out_collector
  import grammer_pkg::*;
#(
  parameter int DW    = DEFAULT_DW,
  parameter int DEPTH = 4,
  parameter int WIN   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  array_out_collector_if.slave io_bus
);
  localparam int SW = DW + $clog2(WIN);
  localparam int CW = $clog2(WIN);

  // FIFO handshake
  logic          w_full, w_empty, w_push, w_pop, w_drop;
  logic [DW-1:0] w_head;

  assign w_pop  = ~w_empty & io_bus.dout_ready;
  assign w_push = io_bus.in_valid & (~w_full | w_pop);
  assign w_drop = io_bus.in_valid & w_full & ~w_pop;

  sync_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (io_bus.data_in),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign io_bus.dout       = w_head;
  assign io_bus.dout_valid = ~w_empty;

  // Drop counter saturates so a long stall never wraps back to a small value.
  logic [7:0] r_ovf_cnt;
  always_ff @(posedge clk) begin
    if (reset)                         r_ovf_cnt <= '0;
    else if (w_drop && r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
  end

  // Window statistics: every offered sample counts, dropped or not.
  logic [SW-1:0] r_acc_sum, r_stat_sum, w_sum_nxt;
  logic [DW-1:0] r_acc_max, r_acc_min, r_stat_max, r_stat_min;
  logic [DW-1:0] w_max_nxt, w_min_nxt;
  logic [CW-1:0] r_win_cnt;
  logic          r_stat_valid, w_win_last;

  assign w_sum_nxt  = r_acc_sum + SW'(io_bus.data_in);
  assign w_max_nxt  = (io_bus.data_in > r_acc_max) ? io_bus.data_in : r_acc_max;
  assign w_min_nxt  = (io_bus.data_in < r_acc_min) ? io_bus.data_in : r_acc_min;
  assign w_win_last = (r_win_cnt == CW'(WIN-1));

  // Accumulate; on the last sample of a window latch the totals and restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_sum    <= '0;
      r_acc_max    <= '0;
      r_acc_min    <= '1;
      r_win_cnt    <= '0;
      r_stat_sum   <= '0;
      r_stat_max   <= '0;
      r_stat_min   <= '0;
      r_stat_valid <= 1'b0;
    end else begin
      r_stat_valid <= 1'b0;
      if (io_bus.in_valid) begin
        if (w_win_last) begin
          r_stat_sum   <= w_sum_nxt;
          r_stat_max   <= w_max_nxt;
          r_stat_min   <= w_min_nxt;
          r_stat_valid <= 1'b1;
          r_acc_sum    <= '0;
          r_acc_max    <= '0;
          r_acc_min    <= '1;
          r_win_cnt    <= '0;
        end else begin
          r_acc_sum <= w_sum_nxt;
          r_acc_max <= w_max_nxt;
          r_acc_min <= w_min_nxt;
          r_win_cnt <= r_win_cnt + CW'(1);
        end
      end
    end
  end

  // Display sequencer
  disp_state_e   r_state, w_state_nxt;
  logic          r_disp_prev, w_rise;
  logic [DW-1:0] r_snap_max, r_snap_min;
  logic [SW-1:0] r_disp_data;
  logic [1:0]    r_disp_sel;

  assign w_rise = io_bus.sig_display & ~r_disp_prev;

  // State register plus the edge-detect history of sig_display.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= DISP_IDLE;
      r_disp_prev <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_disp_prev <= io_bus.sig_display;
    end
  end

  // Next state: only IDLE listens to the edge; the walk itself is unconditional.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      DISP_IDLE: if (w_rise) w_state_nxt = DISP_SUM;
      DISP_SUM:  w_state_nxt = DISP_MAX;
      DISP_MAX:  w_state_nxt = DISP_MIN;
      DISP_MIN:  w_state_nxt = DISP_IDLE;
      default:   w_state_nxt = DISP_IDLE;
    endcase
  end

  // Registered display outputs driven from the upcoming state. Max/min are
  // snapshotted on entry to SUM so a window closing mid-walk cannot mix sets.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp_sel  <= DISP_SEL_NONE;
      r_disp_data <= '0;
      r_snap_max  <= '0;
      r_snap_min  <= '0;
    end else begin
      r_disp_sel <= disp_sel_of(w_state_nxt);
      case (w_state_nxt)
        DISP_SUM: begin
          r_disp_data <= r_stat_sum;
          r_snap_max  <= r_stat_max;
          r_snap_min  <= r_stat_min;
        end
        DISP_MAX: r_disp_data <= SW'(r_snap_max);
        DISP_MIN: r_disp_data <= SW'(r_snap_min);
        default:  r_disp_data <= '0;
      endcase
    end
  end

  assign io_bus.stat_valid = r_stat_valid;
  assign io_bus.disp_data  = r_disp_data;
  assign io_bus.disp_sel   = r_disp_sel;
  assign io_bus.ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_array_out_collector.sv
// Directed bench for array_out_collector: a cycle table for the FIFO / window /
// display interplay, then hand sequences for saturation, wide sums and reset.
module tb_array_out_collector;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  array_out_collector_if #(.DW(32), .WIN(4)) bus ();

  array_out_collector #(.DW(32), .DEPTH(4), .WIN(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  typedef struct {
    logic        iv;
    logic [31:0] din;
    logic        rdy;
    logic        disp;
    logic        dv;
    logic [31:0] dout;
    logic        sv;
    logic [1:0]  sel;
    logic [33:0] dd;
    logic [7:0]  ovf;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic iv, input logic [31:0] din, input logic rdy,
                              input logic disp, input logic dv, input logic [31:0] dout,
                              input logic sv, input logic [1:0] sel, input logic [33:0] dd,
                              input logic [7:0] ovf);
    vec_t v;
    v.iv = iv; v.din = din; v.rdy = rdy; v.disp = disp;
    v.dv = dv; v.dout = dout; v.sv = sv; v.sel = sel; v.dd = dd; v.ovf = ovf;
    return v;
  endfunction

  task automatic check(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic iv, input logic [31:0] din, input logic rdy,
                      input logic disp);
    bus.in_valid    = iv;
    bus.data_in     = din;
    bus.dout_ready  = rdy;
    bus.sig_display = disp;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset(input int idx);
    check("rst_dout_valid", idx, 64'(bus.dout_valid), 64'd0);
    check("rst_dout",       idx, 64'(bus.dout),       64'd0);
    check("rst_stat_valid", idx, 64'(bus.stat_valid), 64'd0);
    check("rst_disp_sel",   idx, 64'(bus.disp_sel),   64'd0);
    check("rst_disp_data",  idx, 64'(bus.disp_data),  64'd0);
    check("rst_ovf_cnt",    idx, 64'(bus.ovf_cnt),    64'd0);
  endtask

  initial begin
    // iv  din     rdy   disp  | dv   dout    sv    sel   disp_data  ovf
    // window {5,7,3,9}, sink always ready
    tbl[0]  = mk(1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd5, 1'b0, 2'd0, 34'd0,  8'd0);
    tbl[1]  = mk(1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 32'd7, 1'b0, 2'd0, 34'd0,  8'd0);
    tbl[2]  = mk(1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 32'd3, 1'b0, 2'd0, 34'd0,  8'd0);
    tbl[3]  = mk(1'b1, 32'd9, 1'b1, 1'b0, 1'b1, 32'd9, 1'b1, 2'd0, 34'd0,  8'd0);
    tbl[4]  = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 34'd0,  8'd0);
    // display that window; level held high must not retrigger
    tbl[5]  = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'd1, 34'd24, 8'd0);
    tbl[6]  = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'd2, 34'd9,  8'd0);
    tbl[7]  = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'd3, 34'd3,  8'd0);
    tbl[8]  = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 2'd0, 34'd0,  8'd0);
    tbl[9]  = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 34'd0,  8'd0);
    // stalled sink, words 1..6: 1..4 kept, 5 and 6 dropped
    tbl[10] = mk(1'b1, 32'd1, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 2'd0, 34'd0,  8'd0);
    tbl[11] = mk(1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 2'd0, 34'd0,  8'd0);
    tbl[12] = mk(1'b1, 32'd3, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 2'd0, 34'd0,  8'd0);
    tbl[13] = mk(1'b1, 32'd4, 1'b0, 1'b0, 1'b1, 32'd1, 1'b1, 2'd0, 34'd0,  8'd0);
    tbl[14] = mk(1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 2'd0, 34'd0,  8'd1);
    tbl[15] = mk(1'b1, 32'd6, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 2'd0, 34'd0,  8'd2);
    // full FIFO with simultaneous push and pop; window {5,6,7,8} closes
    tbl[16] = mk(1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 32'd2, 1'b0, 2'd0, 34'd0,  8'd2);
    tbl[17] = mk(1'b1, 32'd8, 1'b1, 1'b0, 1'b1, 32'd3, 1'b1, 2'd0, 34'd0,  8'd2);
    // display sum 26 / max 8 / min 5 with sink stalled
    tbl[18] = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 2'd1, 34'd26, 8'd2);
    tbl[19] = mk(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'd3, 1'b0, 2'd2, 34'd8,  8'd2);
    tbl[20] = mk(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 2'd3, 34'd5,  8'd2);
    // edge lands while in MIN: ignored. Drain shows 4 entries 3,4,7,8
    tbl[21] = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd4, 1'b0, 2'd0, 34'd0,  8'd2);
    tbl[22] = mk(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd7, 1'b0, 2'd0, 34'd0,  8'd2);
    tbl[23] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 32'd8, 1'b0, 2'd0, 34'd0,  8'd2);
    tbl[24] = mk(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 2'd0, 34'd0,  8'd2);

    // reset
    reset = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
    check_idle_reset(0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].iv, tbl[i].din, tbl[i].rdy, tbl[i].disp);
      check("dout_valid", i, 64'(bus.dout_valid), 64'(tbl[i].dv));
      check("dout",       i, 64'(bus.dout),       64'(tbl[i].dout));
      check("stat_valid", i, 64'(bus.stat_valid), 64'(tbl[i].sv));
      check("disp_sel",   i, 64'(bus.disp_sel),   64'(tbl[i].sel));
      check("disp_data",  i, 64'(bus.disp_data),  64'(tbl[i].dd));
      check("ovf_cnt",    i, 64'(bus.ovf_cnt),    64'(tbl[i].ovf));
    end

    // all-ones window: sum needs the two extra bits
    reset = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    check_idle_reset(1);
    for (int k = 0; k < 4; k++) step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("ones_stat_valid", 0, 64'(bus.stat_valid), 64'd1);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    check("ones_sum_sel", 0, 64'(bus.disp_sel),  64'd1);
    check("ones_sum",     0, 64'(bus.disp_data), 64'h3_FFFF_FFFC);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    check("ones_max", 0, 64'(bus.disp_data), 64'hFFFF_FFFF);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("ones_min", 0, 64'(bus.disp_data), 64'hFFFF_FFFF);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("ones_done_sel", 0, 64'(bus.disp_sel), 64'd0);

    // 262 words into a stalled sink: 258 drops saturate at 255; window
    // 1256..1259 is the last completed, two samples left pending
    for (int k = 0; k < 262; k++) step(1'b1, 32'(1000 + k), 1'b0, 1'b0);
    check("sat_ovf",  0, 64'(bus.ovf_cnt), 64'd255);
    check("sat_dout", 0, 64'(bus.dout),    64'd1000);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    check("sat_sum", 0, 64'(bus.disp_data), 64'd5030);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    check("sat_max_sel", 0, 64'(bus.disp_sel),  64'd2);
    check("sat_max",     0, 64'(bus.disp_data), 64'd1259);

    // reset while in MAX with two samples pending
    reset = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b0);
    reset = 1'b0;
    check_idle_reset(2);
    step(1'b1, 32'd1, 1'b1, 1'b0);
    check("fresh_sv", 1, 64'(bus.stat_valid), 64'd0);
    step(1'b1, 32'd2, 1'b1, 1'b0);
    check("fresh_sv", 2, 64'(bus.stat_valid), 64'd0);
    step(1'b1, 32'd3, 1'b1, 1'b0);
    check("fresh_sv", 3, 64'(bus.stat_valid), 64'd0);
    step(1'b1, 32'd4, 1'b1, 1'b0);
    check("fresh_sv", 4, 64'(bus.stat_valid), 64'd1);
    step(1'b0, 32'd0, 1'b1, 1'b1);
    check("fresh_sum", 0, 64'(bus.disp_data), 64'd10);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("fresh_max", 0, 64'(bus.disp_data), 64'd4);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("fresh_min", 0, 64'(bus.disp_data), 64'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0);
    check("fresh_idle_sel", 0, 64'(bus.disp_sel), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
